det_seq_ctrl: RTL
=================

# det_seq_ctrl

Sequencer that shares one serial sequence detector (single-bit input `w`, Moore output `z`) among word-level producers. It accepts a parallel word over a valid/ready handshake and clears the detector. It then shifts the word into the detector MSB-first, counts the cycles in which the detector flags a match, and returns the match count over a second valid/ready handshake. It sits between the lab's parallel stimulus source and the detector instance.

## Interface
- `WIDTH`, 8: bits per input word, ≥2
- `CNT_W`, 4: match-count width; count saturates at 2^CNT_W−1
- `LAT`, 2: cycles from `det_w` driven to the corresponding `det_z` being valid, ≥1
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-high; all state cleared immediately
- `in_valid` in 1: producer word valid
- `in_data` in WIDTH: word to scan
- `in_ready` out 1: controller can accept a word
- `out_valid` out 1: match count available
- `out_count` out CNT_W: number of matches in the last word
- `out_ready` in 1: consumer accepts the count
- `det_reset` out 1: detector reset, active-high
- `det_w` out 1: detector serial input
- `det_z` in 1: detector match output
- `busy` out 1: high in every state except IDLE

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, REPORT.
- IDLE: `in_ready`=1. On `in_valid & in_ready`, latch `in_data` into the shift register and go to CLEAR.
- CLEAR (1 cycle): `det_reset`=1. Clear the bit index, the match count and the sample pipeline. Go to SHIFT.
- SHIFT (WIDTH cycles): `det_w` = shift-register MSB. Each cycle, shift left with zero fill and increment the index. After the cycle with index WIDTH−1, go to DRAIN.
- DRAIN (LAT cycles): `det_w`=0. Collect the remaining samples, then go to REPORT.
- REPORT: `out_valid`=1 and `out_count` is held stable. On `out_ready`, go to IDLE.
- Sample pipeline: a LAT-deep shift of a "bit driven" flag, set to 1 on each SHIFT cycle. Count increments when the pipeline output is 1 and `det_z`=1, saturating at all-ones.
- `det_reset` = `reset` OR (state==CLEAR). `reset` is the only combinational path to an output.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside REPORT.
- Reset mid-operation: the word in flight is discarded and no count is reported. The state returns to IDLE.

## Timing
- Values while/after reset: `in_ready`=0 while `reset` is high, then 1 (IDLE). `out_valid`=0, `out_count`=0, `det_w`=0, `busy`=0, `det_reset`=1 while `reset` is high.
- Word accepted at edge T: CLEAR is cycle T+1, SHIFT is T+2..T+1+WIDTH, DRAIN is T+2+WIDTH..T+1+WIDTH+LAT.
- `out_valid` rises at T+2+WIDTH+LAT. With the defaults, accept-to-result latency is 12 cycles.
- If `out_ready` is already high when `out_valid` rises, the count transfers in that one cycle. IDLE follows on the next cycle, and `in_ready` is 1 again.
- Back-to-back words: minimum period is WIDTH+LAT+3 cycles. There is no input buffering.
- `out_count` and `out_valid` are registered. `det_w` is registered from the shift-register MSB.

## Structure
- Shared package `det_seq_pkg`:
  - state enum (3-bit encoding: IDLE=0, CLEAR=1, SHIFT=2, DRAIN=3, REPORT=4)
  - default values of WIDTH, CNT_W and LAT
- Sub-module `det_sample_pipe`: LAT-deep valid pipeline plus the saturating CNT_W counter. It has clear, push and `det_z` inputs and a count output.
- Top level holds the FSM, shift register and bit index.

## Test plan
Each scenario uses a bench stub where `det_z` equals `det_w` delayed LAT cycles, so the expected count is the popcount of the word.
- Reset release, idle 5 cycles → `in_ready`=1, `out_valid`=0, `det_w`=0, `busy`=0, `det_reset` low after reset falls.
- Word 8'hB5 accepted at T, `out_ready`=1 → `det_reset` high at T+1 only. `det_w` runs 1,0,1,1,0,1,0,1 over T+2..T+9. `out_valid` at T+12 with count 5.
- Word 8'h00 then 8'hFF, `out_ready` held low 3 cycles → counts 0 then 8. `out_count` stays stable while `out_valid`=1 and `out_ready`=0. `in_valid` is ignored while busy.
- CNT_W=2 with word 8'hFF → count saturates at 3.
- `reset` pulsed during SHIFT of 8'hFF → `out_valid` never rises. The next word 8'h03 reports 2.

Source files
------------

// File: rtl/det_seq_pkg.sv
// det_seq_pkg: shared definitions for the detector sequencer.
//   state_t       - controller FSM state encoding (3 bits)
//   DEF_WIDTH     - default word width
//   DEF_CNT_W     - default match-count width
//   DEF_LAT       - default detector latency (det_w to det_z)
package det_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_LAT   = 2;

endpackage

// File: rtl/det_sample_pipe.sv
// det_sample_pipe: tracks which detector outputs belong to driven bits and
// counts matches.
//   clk, reset - clock and asynchronous active-high reset
//   clear      - synchronous clear of pipeline and count
//   push       - a bit is being driven into the detector this cycle
//   det_z      - detector match output
//   count      - saturating number of qualified matches
module det_sample_pipe
  import det_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int LAT   = DEF_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             det_z,
  output logic [CNT_W-1:0] count
);

  logic [LAT-1:0]   pipe_reg;
  logic [LAT-1:0]   pipe_next;
  logic [CNT_W-1:0] count_reg;
  logic             sample;

  // Shift in the "bit driven" flag; the low LAT bits of the concatenation
  // are the shifted pipeline for any LAT >= 1.
  always_comb begin
    pipe_next = LAT'({pipe_reg, push});
  end

  // The oldest flag lines up with det_z for the bit driven LAT cycles ago.
  assign sample = pipe_reg[LAT-1] & det_z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_reg  <= '0;
      count_reg <= '0;
    end else if (clear) begin
      pipe_reg  <= '0;
      count_reg <= '0;
    end else begin
      pipe_reg <= pipe_next;
      if (sample && (count_reg != {CNT_W{1'b1}})) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/det_seq_ctrl.sv
// det_seq_ctrl: feeds parallel words MSB-first into a shared serial sequence
// detector and returns the number of cycles the detector flagged a match.
//   clk, reset          - clock and asynchronous active-high reset
//   in_valid/in_ready   - word input handshake, in_data is the word
//   out_valid/out_ready - result handshake, out_count is the match count
//   det_reset           - detector reset (also asserted while reset is high)
//   det_w               - detector serial input (registered)
//   det_z               - detector match output
//   busy                - controller is not idle
module det_seq_ctrl
  import det_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int LAT   = DEF_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  input  logic             out_ready,
  output logic             det_reset,
  output logic             det_w,
  input  logic             det_z,
  output logic             busy
);

  localparam int IW = $clog2(WIDTH);
  localparam int DW = $clog2(LAT + 1);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] sreg_reg;
  logic [IW-1:0]    idx_reg;
  logic [DW-1:0]    drain_reg;
  logic             det_w_reg;
  logic             shift_en;
  logic             accept;

  assign accept = (state_reg == ST_IDLE) && in_valid;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:   if (in_valid) state_next = ST_CLEAR;
      ST_CLEAR:  state_next = ST_SHIFT;
      ST_SHIFT:  if (idx_reg == IW'(WIDTH - 1)) state_next = ST_DRAIN;
      ST_DRAIN:  if (drain_reg == DW'(LAT - 1)) state_next = ST_REPORT;
      ST_REPORT: if (out_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // det_w is registered, so the MSB is loaded on the edge that enters (or
  // stays in) SHIFT; this makes det_w valid exactly during SHIFT cycles.
  assign shift_en = (state_next == ST_SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      sreg_reg  <= '0;
      idx_reg   <= '0;
      drain_reg <= '0;
      det_w_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      det_w_reg <= shift_en ? sreg_reg[WIDTH-1] : 1'b0;
      if (accept) begin
        sreg_reg <= in_data;
      end else if (shift_en) begin
        sreg_reg <= {sreg_reg[WIDTH-2:0], 1'b0};
      end
      if (state_reg == ST_CLEAR) begin
        idx_reg   <= '0;
        drain_reg <= '0;
      end
      if (state_reg == ST_SHIFT) begin
        idx_reg <= idx_reg + IW'(1);
      end
      if (state_reg == ST_DRAIN) begin
        drain_reg <= drain_reg + DW'(1);
      end
    end
  end

  det_sample_pipe #(
    .CNT_W(CNT_W),
    .LAT  (LAT)
  ) u_pipe (
    .clk  (clk),
    .reset(reset),
    .clear(state_reg == ST_CLEAR),
    .push (state_reg == ST_SHIFT),
    .det_z(det_z),
    .count(out_count)
  );

  // reset is the only combinational path to the outputs.
  assign in_ready  = (state_reg == ST_IDLE) && !reset;
  assign out_valid = (state_reg == ST_REPORT);
  assign busy      = (state_reg != ST_IDLE);
  assign det_reset = reset || (state_reg == ST_CLEAR);
  assign det_w     = det_w_reg;

endmodule
